mmio_console_port: RTL and testbench
====================================

// Module: mmio_console_port
// PURPOSE
//  Memory-mapped console responder on the data-memory side of the pipelined cpu.
//  Decodes cpu stores to a small register window and queues the low byte of each TXDATA store in a FIFO.
//  Drains the FIFO as a byte stream to a downstream sink (UART, testbench log) over a valid/ready handshake.
//  Sits beside data_memory. It decodes ALUOutM/WriteDataM/MemWriteM-style signals in the M stage.
// PARAMETERS
//  BASE_ADDR   32'hFFFF_0000  16-byte aligned base of register window
//  FIFO_DEPTH  8              byte entries; power of two, >= 2
//  CNT_W       $clog2(FIFO_DEPTH+1)  width of occupancy count (derived, localparam)
// PORTS
//  clk        in   1   single clock, all state updates on posedge
//  reset      in   1   synchronous, active-high
//  addr       in   32  cpu M-stage address
//  wdata      in   32  cpu store data
//  mem_write  in   1   store strobe, sampled at posedge
//  mem_read   in   1   load strobe (qualifies rdata only)
//  hit        out  1   addr[31:4]==BASE_ADDR[31:4], combinational
//  rdata      out  32  read data, combinational
//  out_byte   out  8   FIFO head byte
//  out_valid  out  1   FIFO non-empty
//  out_ready  in   1   sink accepts out_byte this cycle
// BEHAVIOUR
//  Register map (offset = addr[3:2]):
//   0 TXDATA  W: push wdata[7:0]; R: 0
//   1 STATUS  R: {16'b0, count[7:0], 5'b0, overflow, empty, full}; W: ignored
//   2 CTRL    W: bit0 clear FIFO, bit1 clear overflow; R: 0
//   3 rsvd    R: 0, W: ignored
//  - Zero-extend count into [15:8].
//  - rdata = 0 when !hit or !mem_read.
//  - No access has side effects on reads.
//  Reset (reset=1 at posedge):
//   - count=0, rd/wr pointers=0, overflow=0.
//   - out_valid=0; out_byte=0 when empty.
//   - A reset during a handshake drops all queued bytes; no pop occurs that cycle.
//  Push: hit & mem_write & offset==0.
//   - Byte is visible on out_byte/out_valid the cycle after the store edge. Write-to-valid latency is 1.
//  Pop: out_valid & out_ready at posedge.
//   - Head advances; next byte is presented the following cycle.
//   - Streams back-to-back at one byte per cycle.
//  FIFO is first-word-fall-through. out_byte is held stable while out_valid & !out_ready.
//  Full (count==FIFO_DEPTH):
//   - Push with no pop in the same cycle: byte dropped, overflow set (sticky).
//   - Push and pop in the same cycle: both take effect; count unchanged; no overflow.
//  Empty: a push and an out_ready in the same cycle are not a pop. Only the push takes effect.
//  Pointers wrap modulo FIFO_DEPTH. count is independent of the pointers, so full and empty are unambiguous.
//  CTRL bit0 (clear FIFO):
//   - Pointers and count go to 0; any concurrent pop is discarded.
//   - out_valid drops the next cycle; this is the only permitted valid withdrawal.
//  CTRL bit1 clears overflow. If an overflowing push and a clear land in the same cycle, the clear wins.
//  Stores with !hit, or with offset 1 or 3, change no state.
// TESTING
//  1 reset held 2 cycles -> out_valid=0, STATUS read = 32'h0000_0002 (empty).
//  2 out_ready=1; store 'H','i',8'h0A to BASE+0 on 3 consecutive cycles -> out_byte 48,69,0A with out_valid each on cycles +1..+3.
//  3 out_ready=0; 9 pushes 0x01..0x09 -> STATUS = 32'h0000_0805 (count 8, full, overflow); drain yields 01..08 only.
//  4 FIFO full, out_ready=1, push 0x55 in the same cycle -> count stays 8, overflow=0, 0x55 emerges last.
//  5 out_ready=0 with 3 queued; out_byte stable 5 cycles; CTRL write 32'h3 -> next cycle out_valid=0, STATUS=32'h0000_0002.
//  6 out_ready=1 mid-stream with 4 queued; reset asserted 1 cycle -> no further out_valid; later push of 0xAA comes out alone.

Source files
------------

// File: rtl/mmio_console_port.sv
// Memory-mapped console port: decodes M-stage stores to a 16-byte register
// window, queues TXDATA bytes in a first-word-fall-through FIFO and streams
// them out over a valid/ready handshake.
module mmio_console_port #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_write,
  input  logic        mem_read,
  output logic        hit,
  output logic [31:0] rdata,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    OffTxData = 2'd0,
    OffStatus = 2'd1,
    OffCtrl   = 2'd2,
    OffRsvd   = 2'd3
  } offset_e;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  offset_e    offset;
  logic       empty, full;
  logic       push_req, push, pop;
  logic       ctrl_wr, clr_fifo, clr_ovf;
  logic [7:0] count8;
  logic       unused;

  assign hit      = addr[31:4] == BASE_ADDR[31:4];
  assign offset   = offset_e'(addr[3:2]);
  assign empty    = count_q == '0;
  assign full     = count_q == CNT_W'(FIFO_DEPTH);
  assign count8   = 8'(count_q);

  assign push_req = hit & mem_write & (offset == OffTxData);
  assign ctrl_wr  = hit & mem_write & (offset == OffCtrl);
  assign clr_fifo = ctrl_wr & wdata[0];
  assign clr_ovf  = ctrl_wr & wdata[1];

  // A clear discards any pop that would otherwise happen this cycle.
  assign pop      = out_valid & out_ready & ~clr_fifo;
  // When full, a push only fits if the head leaves in the same cycle.
  assign push     = push_req & (~full | pop);

  assign out_valid = ~empty;
  assign out_byte  = empty ? 8'h00 : mem_q[rd_ptr_q];

  assign unused = ^{addr[1:0], wdata[31:8]};

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clr_fifo) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
    if (push_req && full && !pop) begin
      overflow_d = 1'b1;
    end
    // Clear wins over a coincident overflowing push.
    if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Byte storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= wdata[7:0];
    end
  end

  // Register read mux; only STATUS returns non-zero data.
  always_comb begin
    rdata = '0;
    if (hit && mem_read && (offset == OffStatus)) begin
      rdata = {16'b0, count8, 5'b0, overflow_q, empty, full};
    end
  end

endmodule

// File: tb/tb_mmio_console_port.sv
// Bench for mmio_console_port: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a queue model.
module tb_mmio_console_port;

  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata, rdata;
  logic        mem_write, mem_read, hit;
  logic [7:0]  out_byte;
  logic        out_valid, out_ready;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [7:0] q_m[$];
  bit         ovf_m  = 1'b0;
  bit         live_m = 1'b0;

  mmio_console_port #(
    .BASE_ADDR (BASE),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .wdata    (wdata),
    .mem_write(mem_write),
    .mem_read (mem_read),
    .hit      (hit),
    .rdata    (rdata),
    .out_byte (out_byte),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    addr      = 32'h0;
    wdata     = 32'h0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr      = a;
    wdata     = d;
    mem_write = 1'b1;
    mem_read  = 1'b0;
  endtask

  // Queue-level model: the head leaves if the queue was non-empty and the sink
  // was ready; the byte joins if there is room after that; a CTRL clear empties.
  initial forever begin
    @(posedge clk);
    if (reset) begin
      q_m.delete();
      ovf_m  = 1'b0;
      live_m = 1'b1;
    end else if (live_m) begin
      bit       hit_m, was_pop;
      bit [1:0] off;
      hit_m = addr[31:4] == BASE[31:4];
      off   = addr[3:2];
      if (hit_m && mem_write && off == 2'd2 && wdata[0]) begin
        q_m.delete();
      end else begin
        was_pop = (q_m.size() > 0) && out_ready;
        if (was_pop) void'(q_m.pop_front());
        if (hit_m && mem_write && off == 2'd0) begin
          if (q_m.size() < DEPTH) q_m.push_back(wdata[7:0]);
          else ovf_m = 1'b1;
        end
      end
      if (hit_m && mem_write && off == 2'd2 && wdata[1]) ovf_m = 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (live_m && !reset) begin
      bit          hit_e;
      logic [31:0] rd_e;
      logic [7:0]  cnt;
      hit_e = addr[31:4] == BASE[31:4];
      cnt   = 8'(q_m.size());
      rd_e  = 32'h0;
      if (hit_e && mem_read && addr[3:2] == 2'd1)
        rd_e = {16'h0, cnt, 5'b0, ovf_m, q_m.size() == 0, q_m.size() == DEPTH};
      check("m_hit", {31'b0, hit}, {31'b0, hit_e});
      check("m_valid", {31'b0, out_valid}, {31'b0, q_m.size() > 0});
      check("m_byte", {24'b0, out_byte}, {24'b0, (q_m.size() > 0) ? q_m[0] : 8'h00});
      check("m_rdata", rdata, rd_e);
    end
  end

  logic [7:0] exp4 [8];
  logic [7:0] b0;

  initial begin
    reset = 1'b1;
    out_ready = 1'b0;
    idle();
    // 1: reset two cycles, then read STATUS.
    tick();
    tick();
    reset = 1'b0;
    mem_read = 1'b1;
    addr = BASE + 32'h4;
    @(negedge clk);
    check("t1_valid", {31'b0, out_valid}, 32'h0);
    check("t1_status", rdata, 32'h0000_0002);
    tick();

    // 2: back-to-back streaming.
    out_ready = 1'b1;
    store(BASE, 32'h48);
    tick();
    store(BASE, 32'h69);
    @(negedge clk);
    check("t2_b0", {24'b0, out_byte}, 32'h48);
    check("t2_v0", {31'b0, out_valid}, 32'h1);
    tick();
    store(BASE, 32'h0A);
    @(negedge clk);
    check("t2_b1", {24'b0, out_byte}, 32'h69);
    tick();
    idle();
    @(negedge clk);
    check("t2_b2", {24'b0, out_byte}, 32'h0A);
    tick();
    @(negedge clk);
    check("t2_done", {31'b0, out_valid}, 32'h0);

    // 3: overflow on the ninth push.
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      store(BASE, 32'(i));
      tick();
    end
    idle();
    mem_read = 1'b1;
    addr = BASE + 32'h4;
    @(negedge clk);
    check("t3_status", rdata, 32'h0000_0805);
    tick();
    store(BASE + 32'h8, 32'h2);
    tick();
    idle();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("t3_drain", {24'b0, out_byte}, 32'(i));
      tick();
    end
    @(negedge clk);
    check("t3_empty", {31'b0, out_valid}, 32'h0);

    // 4: push while full and popping.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      store(BASE, 32'h10 + 32'(i));
      tick();
    end
    out_ready = 1'b1;
    store(BASE, 32'h55);
    tick();
    idle();
    out_ready = 1'b0;
    mem_read = 1'b1;
    addr = BASE + 32'h4;
    @(negedge clk);
    check("t4_status", rdata, 32'h0000_0801);
    tick();
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) exp4[i] = 8'h11 + 8'(i);
    exp4[7] = 8'h55;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t4_drain", {24'b0, out_byte}, {24'b0, exp4[i]});
      tick();
    end

    // 5: stall holds the head, then clear FIFO and overflow.
    out_ready = 1'b0;
    b0 = 8'($urandom);
    store(BASE, {24'b0, b0});
    tick();
    for (int i = 0; i < 2; i++) begin
      store(BASE, $urandom);
      tick();
    end
    idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_hold", {23'b0, out_valid, out_byte}, {23'b0, 1'b1, b0});
      tick();
    end
    store(BASE + 32'h8, 32'h3);
    tick();
    idle();
    mem_read = 1'b1;
    addr = BASE + 32'h4;
    @(negedge clk);
    check("t5_valid", {31'b0, out_valid}, 32'h0);
    check("t5_status", rdata, 32'h0000_0002);
    tick();

    // 6: reset mid-stream drops everything.
    idle();
    for (int i = 0; i < 4; i++) begin
      store(BASE, 32'hC0 + 32'(i));
      tick();
    end
    idle();
    out_ready = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_quiet", {31'b0, out_valid}, 32'h0);
      tick();
    end
    store(BASE, 32'hAA);
    tick();
    idle();
    @(negedge clk);
    check("t6_aa", {23'b0, out_valid, out_byte}, 32'h1AA);
    tick();
    @(negedge clk);
    check("t6_alone", {31'b0, out_valid}, 32'h0);

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      int sel;
      tick();
      reset     = ($urandom_range(0, 299) == 0);
      out_ready = ($urandom_range(0, 99) < (((i / 250) % 2 == 1) ? 20 : 85));
      mem_write = $urandom_range(0, 1) == 1;
      mem_read  = $urandom_range(0, 1) == 1;
      wdata     = $urandom;
      sel       = int'($urandom_range(0, 15));
      if (sel <= 9) addr = BASE;
      else if (sel == 10) addr = BASE + 32'h4;
      else if (sel == 11) begin
        addr = BASE + 32'h8;
        if ($urandom_range(0, 3) != 0) wdata[0] = 1'b0;
      end else if (sel == 12) addr = BASE + 32'hC;
      else if (sel == 13) addr = $urandom;
      else addr = BASE ^ (32'h1 << $urandom_range(4, 31));
      addr[1:0] = 2'($urandom);
    end
    tick();
    reset = 1'b0;
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
